// File: rtl/sram_initiator.sv
// sram_initiator: valid/ready request front end for one single-port tc_sram.
// Tracks the SRAM read latency with a tag pipe and returns in-order responses
// through a credit-protected FIFO so stalled consumers never lose read data.
// Optional feature macro: SRAM_INITIATOR_RANGE_CHECK_EN adds out-of-range
// address detection with error responses; without it addresses are truncated.
module sram_initiator #(
    parameter int unsigned NumWords  = 1024,
    parameter int unsigned DataWidth = 32,
    parameter int unsigned ByteWidth = 8,
    parameter int unsigned Latency   = 1,
    parameter int unsigned RspDepth  = 4,
    parameter int unsigned AddrWidth = (NumWords > 1) ? $clog2(NumWords) : 1,
    parameter int unsigned BeWidth   = (DataWidth + ByteWidth - 1) / ByteWidth
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 req_valid_i,
    output logic                 req_ready_o,
    input  logic                 req_we_i,
    input  logic [31:0]          req_addr_i,
    input  logic [DataWidth-1:0] req_wdata_i,
    input  logic [BeWidth-1:0]   req_be_i,
    output logic                 rsp_valid_o,
    input  logic                 rsp_ready_i,
    output logic [DataWidth-1:0] rsp_rdata_o,
    output logic                 rsp_err_o,
    output logic                 sram_req_o,
    output logic                 sram_we_o,
    output logic [AddrWidth-1:0] sram_addr_o,
    output logic [DataWidth-1:0] sram_wdata_o,
    output logic [BeWidth-1:0]   sram_be_o,
    input  logic [DataWidth-1:0] sram_rdata_i
);

    localparam int unsigned CntWidth = $clog2(RspDepth + 1);
    localparam int unsigned PtrWidth = (RspDepth > 1) ? $clog2(RspDepth) : 1;

    logic                 accept;
    logic                 in_range;
    logic                 fifo_push;
    logic                 fifo_pop;
    logic [DataWidth-1:0] push_data;

    logic [CntWidth-1:0]  count_q;
    logic [Latency-1:0]   pipe_valid_q;
    logic [Latency-1:0]   pipe_read_q;

    logic [DataWidth-1:0] fifo_data_q [RspDepth];
    logic [PtrWidth-1:0]  wptr_q;
    logic [PtrWidth-1:0]  rptr_q;
    logic [CntWidth-1:0]  fifo_cnt_q;

`ifdef SRAM_INITIATOR_RANGE_CHECK_EN
    logic [Latency-1:0]   pipe_err_q;
    logic [RspDepth-1:0]  fifo_err_q;
    logic                 push_err;
`endif

    // Pointer advance with explicit wrap so non-power-of-two depths work.
    function automatic logic [PtrWidth-1:0] next_ptr(input logic [PtrWidth-1:0] p);
        return (p == PtrWidth'(RspDepth - 1)) ? '0 : p + 1'b1;
    endfunction

    // Credits come from registered state only, so ready never depends on rsp_ready_i.
    assign req_ready_o = (count_q < CntWidth'(RspDepth));
    assign accept      = req_valid_i && req_ready_o;

`ifdef SRAM_INITIATOR_RANGE_CHECK_EN
    assign in_range = (req_addr_i < 32'(NumWords));
`else
    assign in_range = 1'b1;
    logic unused_addr_bits;
    assign unused_addr_bits = ^req_addr_i[31:AddrWidth];
`endif

    // SRAM port is driven straight from the accepted request; error requests stay off the SRAM.
    assign sram_req_o   = accept && in_range;
    assign sram_we_o    = sram_req_o ? req_we_i : 1'b0;
    assign sram_addr_o  = sram_req_o ? req_addr_i[AddrWidth-1:0] : '0;
    assign sram_wdata_o = sram_req_o ? req_wdata_i : '0;
    assign sram_be_o    = sram_req_o ? req_be_i : '0;

    assign fifo_push   = pipe_valid_q[Latency-1];
    assign rsp_valid_o = (fifo_cnt_q != '0);
    assign fifo_pop    = rsp_valid_o && rsp_ready_i;

`ifdef SRAM_INITIATOR_RANGE_CHECK_EN
    assign push_err  = pipe_err_q[Latency-1];
    assign push_data = (pipe_read_q[Latency-1] && !push_err) ? sram_rdata_i : '0;
    assign rsp_err_o = rsp_valid_o ? fifo_err_q[rptr_q] : 1'b0;
`else
    assign push_data = pipe_read_q[Latency-1] ? sram_rdata_i : '0;
    assign rsp_err_o = 1'b0;
`endif

    assign rsp_rdata_o = rsp_valid_o ? fifo_data_q[rptr_q] : '0;

    // Tag pipe: one stage per cycle of SRAM read latency, aligned with sram_rdata_i at its output.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            pipe_valid_q <= '0;
            pipe_read_q  <= '0;
`ifdef SRAM_INITIATOR_RANGE_CHECK_EN
            pipe_err_q   <= '0;
`endif
        end else begin
            pipe_valid_q[0] <= accept;
            pipe_read_q[0]  <= accept && !req_we_i;
`ifdef SRAM_INITIATOR_RANGE_CHECK_EN
            pipe_err_q[0]   <= accept && !in_range;
`endif
            for (int i = 1; i < Latency; i++) begin
                pipe_valid_q[i] <= pipe_valid_q[i-1];
                pipe_read_q[i]  <= pipe_read_q[i-1];
`ifdef SRAM_INITIATOR_RANGE_CHECK_EN
                pipe_err_q[i]   <= pipe_err_q[i-1];
`endif
            end
        end
    end

    // Credit counter: grows on accept, shrinks on pop, covers pipe plus FIFO.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            count_q <= '0;
        end else begin
            case ({accept, fifo_pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

    // FIFO pointers and occupancy; simultaneous push and pop keep occupancy unchanged.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wptr_q     <= '0;
            rptr_q     <= '0;
            fifo_cnt_q <= '0;
        end else begin
            if (fifo_push) wptr_q <= next_ptr(wptr_q);
            if (fifo_pop)  rptr_q <= next_ptr(rptr_q);
            case ({fifo_push, fifo_pop})
                2'b10:   fifo_cnt_q <= fifo_cnt_q + 1'b1;
                2'b01:   fifo_cnt_q <= fifo_cnt_q - 1'b1;
                default: fifo_cnt_q <= fifo_cnt_q;
            endcase
        end
    end

    // FIFO storage needs no reset; outputs are masked while the FIFO is empty.
    always_ff @(posedge clk_i) begin
        if (fifo_push) begin
            fifo_data_q[wptr_q] <= push_data;
`ifdef SRAM_INITIATOR_RANGE_CHECK_EN
            fifo_err_q[wptr_q]  <= push_err;
`endif
        end
    end

    // Credits make a push into a full FIFO without a pop impossible.
    assert property (@(posedge clk_i) disable iff (rst_i)
        !(fifo_push && !fifo_pop && (fifo_cnt_q == CntWidth'(RspDepth))));

endmodule

// File: doc/sram_initiator.md
# sram_initiator

Request-side front end for the single-port `tc_sram` macro. It accepts a valid/ready request stream (read or write), drives the SRAM port, tracks the fixed read latency, and returns one in-order response per request through a credit-protected response FIFO, so no read data is lost when the consumer stalls. It sits between a bus adapter or DMA engine and one `tc_sram` instance with `NumPorts = 1`.

## Interface
- `NumWords`, 1024: SRAM depth in words; must match the attached SRAM.
- `DataWidth`, 32: data width in bits.
- `ByteWidth`, 8: bits per byte-enable lane.
- `Latency`, 1: SRAM read latency in cycles, ≥1; must match the attached SRAM.
- `RspDepth`, 4: response FIFO depth, ≥1.
- `AddrWidth` (derived) = `NumWords > 1 ? $clog2(NumWords) : 1`.
- `BeWidth` (derived) = `ceil(DataWidth / ByteWidth)`.

Ports:
- `clk_i` in 1: clock; the single clock for the block.
- `rst_i` in 1: reset, asynchronous, active-high.
- `req_valid_i` in 1: request valid.
- `req_ready_o` out 1: request ready.
- `req_we_i` in 1: 1 selects write, 0 selects read.
- `req_addr_i` in 32: word address.
- `req_wdata_i` in DataWidth: write data.
- `req_be_i` in BeWidth: write byte enables.
- `rsp_valid_o` out 1: response valid.
- `rsp_ready_i` in 1: response ready.
- `rsp_rdata_o` out DataWidth: read data; 0 for writes and errors.
- `rsp_err_o` out 1: address out of range.
- `sram_req_o` out 1: SRAM request.
- `sram_we_o` out 1: SRAM write enable.
- `sram_addr_o` out AddrWidth: SRAM address.
- `sram_wdata_o` out DataWidth: SRAM write data.
- `sram_be_o` out BeWidth: SRAM byte enables.
- `sram_rdata_i` in DataWidth: SRAM read data.

## Operation
- **Handshake.** A request is accepted when `req_valid_i && req_ready_o` is high on a rising edge. Once `req_valid_i` is raised, the request must hold stable until it is accepted.
- **Credit count.** `count` = in-flight pipe entries + FIFO occupancy, range 0..RspDepth.
  - `req_ready_o = (count < RspDepth)`, computed from registered state only.
  - `req_ready_o` has no combinational path from `rsp_ready_i`.
- **SRAM drive.** The SRAM outputs are combinational from the request:
  - `sram_req_o = accept && in_range`.
  - `sram_we_o = req_we_i`, `sram_addr_o = req_addr_i[AddrWidth-1:0]`.
  - `sram_wdata_o = req_wdata_i`, `sram_be_o = req_be_i`.
  - A request with all-zero `be` is still forwarded.
- **Tag pipe.** Every accepted request pushes a tag {valid, is_read, err} into a `Latency`-stage shift register.
  - At the pipe output, the tag is written into the FIFO.
  - `rdata` = `sram_rdata_i` if `is_read && !err`, else 0.
- **FIFO.** `rsp_valid_o` = FIFO not empty; the entry pops on `rsp_valid_o && rsp_ready_i`.
  - Responses return in strict request order, including writes and errors.
  - A FIFO push and pop in the same cycle leave occupancy unchanged.
- **Error requests** (out-of-range address) are never forwarded to the SRAM (`sram_req_o = 0`) but still produce a response with `rsp_err_o = 1`.
- **No overflow.** The credit check guarantees the FIFO never overflows. An internal overflow condition is unreachable, and an assertion must flag it.
- **Reset** (asynchronous, any time, including mid-operation):
  - Pipe, FIFO and count are cleared; in-flight responses are discarded.
  - Reset values: `req_ready_o = 1`, `rsp_valid_o = 0`, `rsp_rdata_o = 0`, `rsp_err_o = 0`.
  - All SRAM outputs are 0 because `accept = 0`.

## Timing
- Request accepted at edge T → response visible on `rsp_valid_o` from cycle T+Latency+1, with `rsp_ready_i` held high and the FIFO empty.
- A credit is returned in the cycle after the pop.
- Sustained one request per cycle requires `RspDepth ≥ Latency+2`. With a smaller depth, throughput drops but correctness is unaffected.
- If the consumer stalls, at most `RspDepth` requests are accepted. Then `req_ready_o` goes to 0 until a pop occurs.

## Configuration
- `SRAM_INITIATOR_RANGE_CHECK_EN` defined:
  - `in_range = (req_addr_i < NumWords)`.
  - Out-of-range requests return `rsp_err_o = 1`, `rdata = 0`.
- Undefined:
  - `in_range` is tied to 1 and the address is truncated to AddrWidth.
  - `rsp_err_o` is constant 0; the err bit is removed from pipe and FIFO.

## Test plan
- **Write then read.** Latency=1: write addr 5, data 0xDEADBEEF, be 0xF; then read addr 5 → responses in order: (rdata 0, err 0), then (rdata 0xDEADBEEF, err 0) at T+2.
- **Partial write.** Write 0x11223344 to addr 7 with be 0x3 over prior content 0xAAAAAAAA; read addr 7 → 0xAAAA3344.
- **Back-pressure.** RspDepth=4, `rsp_ready_i=0`, 6 back-to-back reads → exactly 4 accepted, `req_ready_o` 0 from then on. Release `rsp_ready_i` → 4 responses in address order, then the remaining 2 accepted.
- **Throughput.** RspDepth=3, Latency=1, `rsp_ready_i=1`, 16 consecutive reads → one accept per cycle, no `req_ready_o` deassertion, responses back-to-back.
- **Range check.** With the range-check macro, NumWords=1024: read addr 1024 → `sram_req_o` stays 0, response err 1, rdata 0, in order between the neighbouring valid reads. Without the macro: addr 1024 aliases addr 0, err 0.
- **Reset mid-operation.** Assert `rst_i` with 2 reads in flight and 1 response queued → `rsp_valid_o` 0 and `req_ready_o` 1 immediately. After release, no stale response appears.
